debounce_button: RTL and testbench

Multi-channel debouncer and event generator for board switches and push-buttons. It generalises the slow-sampled shift-register debouncer with:
- per-channel input polarity;
- a built-in two-stage synchroniser;
- one-cycle press and release pulses;
- long-press detection with optional auto-repeat.

It sits between raw board I/O and the control/CSR logic, so consumers no longer need their own edge detectors.

---
 rtl/debounce_button.sv | 142 ++++++++++++++
 tb/tb_debounce_button.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/debounce_button.sv
// Multi-channel switch/button debouncer with press/release pulses, long-press
// detection and auto-repeat. All channels share one sample-rate divider.
module debounce_button #(
  parameter int unsigned      WIDTH  = 1,
  parameter int unsigned      N      = 3,
  parameter int unsigned      RATE   = 125000,
  parameter logic [WIDTH-1:0] INVERT = '0,
  parameter int unsigned      HOLD   = 100,
  parameter int unsigned      REPEAT = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] long,
  output logic [WIDTH-1:0] rpt,
  output logic             tick
);

  localparam int unsigned CW   = $clog2(RATE);
  localparam int unsigned MAXC = (HOLD > REPEAT) ? HOLD : REPEAT;
  localparam int unsigned HW   = $clog2((MAXC > 2) ? MAXC : 2) + 1;

  localparam logic [CW-1:0] CNT_MAX   = CW'(RATE - 1);
  localparam logic [HW-1:0] HOLD_TC   = (HOLD == 0) ? '0 : HW'(HOLD - 1);
  localparam logic [HW-1:0] REPEAT_TC = (REPEAT == 0) ? '0 : HW'(REPEAT - 1);

  logic [CW-1:0]    cnt_q;
  logic             tick_q;
  logic [WIDTH-1:0] s1_q, s2_q;
  logic [N-1:0]     sh_q [WIDTH];
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rise_q, fall_q;
  logic [WIDTH-1:0] long_q, long_d;
  logic [WIDTH-1:0] rpt_q, rpt_d;
  logic [HW-1:0]    hcnt_q [WIDTH];
  logic [HW-1:0]    hcnt_d [WIDTH];

  // Sample-rate divider; tick is registered so it is a clean one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CNT_MAX);
      cnt_q  <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    end
  end

  // Two-stage synchroniser (polarity applied up front) and per-channel sample history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      for (int k = 0; k < WIDTH; k++) sh_q[k] <= '0;
    end else begin
      s1_q <= in ^ INVERT;
      s2_q <= s1_q;
      if (tick_q) begin
        for (int k = 0; k < WIDTH; k++) sh_q[k] <= {sh_q[k][N-2:0], s2_q[k]};
      end
    end
  end

  // Debounced level: change only on a unanimous sample history.
  always_comb begin
    out_d = out_q;
    for (int k = 0; k < WIDTH; k++) begin
      if (&sh_q[k])       out_d[k] = 1'b1;
      else if (~|sh_q[k]) out_d[k] = 1'b0;
    end
  end

  // Level register plus edge pulses aligned with the first cycle of the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      out_q  <= out_d;
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  // Hold/repeat counter; clearing on a (pending) release wins over a tick so
  // long drops in the same cycle as the fall pulse.
  always_comb begin
    long_d = long_q;
    rpt_d  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      hcnt_d[k] = hcnt_q[k];
      if (!out_d[k]) begin
        hcnt_d[k] = '0;
        long_d[k] = 1'b0;
      end else if (tick_q && out_q[k]) begin
        if (!long_q[k]) begin
          if (HOLD != 0) begin
            if (hcnt_q[k] == HOLD_TC) begin
              long_d[k] = 1'b1;
              rpt_d[k]  = 1'b1;
              hcnt_d[k] = '0;
            end else begin
              hcnt_d[k] = hcnt_q[k] + 1'b1;
            end
          end
        end else if (REPEAT != 0) begin
          if (hcnt_q[k] == REPEAT_TC) begin
            rpt_d[k]  = 1'b1;
            hcnt_d[k] = '0;
          end else begin
            hcnt_d[k] = hcnt_q[k] + 1'b1;
          end
        end
      end
    end
  end

  // Hold/repeat state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q <= '0;
      rpt_q  <= '0;
      for (int k = 0; k < WIDTH; k++) hcnt_q[k] <= '0;
    end else begin
      long_q <= long_d;
      rpt_q  <= rpt_d;
      for (int k = 0; k < WIDTH; k++) hcnt_q[k] <= hcnt_d[k];
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign long = long_q;
  assign rpt  = rpt_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_debounce_button.sv
// Directed bench for debounce_button: main instance (HOLD=5, REPEAT=2) plus
// HOLD=0 and REPEAT=0 variants sharing the same inputs.
module tb_debounce_button;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] in;

  logic [1:0] out_a, rise_a, fall_a, long_a, rpt_a;
  logic       tick_a;
  logic [1:0] out_h, rise_h, fall_h, long_h, rpt_h;
  logic       tick_h;
  logic [1:0] out_r, rise_r, fall_r, long_r, rpt_r;
  logic       tick_r;

  int n_checks = 0;
  int n_fail   = 0;

  // Pulse/level tallies, written only by the monitor below.
  int n_rise0 = 0, n_fall0 = 0, n_rise1 = 0, n_fall1 = 0;
  int n_rpt_a = 0, n_rpt_h = 0, n_long_h = 0, n_rpt_r = 0;
  int b_rise0, b_fall0, b_rise1, b_fall1, b_rpt_a, b_rpt_h, b_long_h, b_rpt_r;

  always #5 clk = ~clk;

  debounce_button #(.WIDTH(2), .N(3), .RATE(4), .INVERT(2'b10), .HOLD(5), .REPEAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .out(out_a), .rise(rise_a), .fall(fall_a),
    .long(long_a), .rpt(rpt_a), .tick(tick_a)
  );

  debounce_button #(.WIDTH(2), .N(3), .RATE(4), .INVERT(2'b10), .HOLD(0), .REPEAT(2)) dut_h0 (
    .clk(clk), .rst_n(rst_n), .in(in), .out(out_h), .rise(rise_h), .fall(fall_h),
    .long(long_h), .rpt(rpt_h), .tick(tick_h)
  );

  debounce_button #(.WIDTH(2), .N(3), .RATE(4), .INVERT(2'b10), .HOLD(5), .REPEAT(0)) dut_r0 (
    .clk(clk), .rst_n(rst_n), .in(in), .out(out_r), .rise(rise_r), .fall(fall_r),
    .long(long_r), .rpt(rpt_r), .tick(tick_r)
  );

  always @(negedge clk) begin
    n_rise0  += int'(rise_a[0]);
    n_fall0  += int'(fall_a[0]);
    n_rise1  += int'(rise_a[1]);
    n_fall1  += int'(fall_a[1]);
    n_rpt_a  += int'(rpt_a[0]);
    n_rpt_h  += int'(rpt_h[0]);
    n_long_h += int'(long_h[0]);
    n_rpt_r  += int'(rpt_r[0]);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    b_rise0 = n_rise0; b_fall0 = n_fall0; b_rise1 = n_rise1; b_fall1 = n_fall1;
    b_rpt_a = n_rpt_a; b_rpt_h = n_rpt_h; b_long_h = n_long_h; b_rpt_r = n_rpt_r;
  endtask

  initial begin
    // Reset / idle: in=10 with INVERT=10 means nothing pressed.
    rst_n = 1'b0;
    in    = 2'b10;
    cyc(3);
    check("reset_outputs", 32'({out_a, rise_a, fall_a, long_a, rpt_a, tick_a}), 32'd0);
    rst_n = 1'b1;                 // edge count restarts: next posedge is E1
    cyc(3);  check("tick_e3", 32'(tick_a), 32'd0);
    cyc(1);  check("tick_e4", 32'(tick_a), 32'd1);
    cyc(1);  check("tick_e5", 32'(tick_a), 32'd0);
    cyc(3);  check("tick_e8", 32'(tick_a), 32'd1);
    check("idle_out", 32'(out_a), 32'd0);

    // Clean press on ch0 (between E8 and E9); shifts at E13/E17/E21 see it.
    snap();
    in = 2'b11;
    cyc(13); check("press_out_e21", 32'(out_a), 32'd0);
    cyc(1);  check("press_out_e22", 32'(out_a), 32'b01);
    check("press_rise_e22", 32'(rise_a), 32'b01);
    cyc(1);  check("press_rise_e23", 32'(rise_a), 32'b00);

    // Long press: 5th tick with out=1 (E41) sets long with rpt, then every 8 cycles.
    cyc(17); check("long_e40", 32'(long_a), 32'b00);
    cyc(1);  check("long_e41", 32'(long_a), 32'b01);
    check("rpt_e41", 32'(rpt_a), 32'b01);
    check("r0_long_e41", 32'(long_r), 32'b01);
    check("r0_rpt_e41", 32'(rpt_r), 32'b01);
    check("h0_long_e41", 32'(long_h), 32'b00);
    cyc(1);  check("rpt_e42", 32'(rpt_a), 32'b00);
    cyc(6);  check("rpt_e48", 32'(rpt_a), 32'b00);
    cyc(1);  check("rpt_e49", 32'(rpt_a), 32'b01);

    // Release after E240; sample history empties at E253, out falls at E254.
    cyc(191);
    in = 2'b10;
    cyc(13); check("rel_out_e253", 32'(out_a), 32'b01);
    check("rel_long_e253", 32'(long_a), 32'b01);
    cyc(1);  check("rel_out_e254", 32'(out_a), 32'b00);
    check("rel_fall_e254", 32'(fall_a), 32'b01);
    check("rel_long_e254", 32'(long_a), 32'b00);
    cyc(1);  check("rel_fall_e255", 32'(fall_a), 32'b00);
    cyc(5);  #1;
    check("press_n_rise0", 32'(n_rise0 - b_rise0), 32'd1);
    check("press_n_fall0", 32'(n_fall0 - b_fall0), 32'd1);
    check("ch1_n_pulses", 32'((n_rise1 - b_rise1) + (n_fall1 - b_fall1)), 32'd0);
    check("main_n_rpt", 32'(n_rpt_a - b_rpt_a), 32'd27);
    check("h0_n_rpt", 32'(n_rpt_h - b_rpt_h), 32'd0);
    check("h0_n_long", 32'(n_long_h - b_long_h), 32'd0);
    check("r0_n_rpt", 32'(n_rpt_r - b_rpt_r), 32'd1);

    // Bounce: 3-cycle toggling never gives 3 equal samples, then settle high.
    snap();
    for (int i = 0; i < 7; i++) begin
      in[0] = 1'b1; cyc(3);
      in[0] = 1'b0; cyc(3);
    end
    in[0] = 1'b1;
    cyc(30); #1;
    check("bounce_out", 32'(out_a), 32'b01);
    check("bounce_n_rise0", 32'(n_rise0 - b_rise0), 32'd1);
    check("bounce_n_fall0", 32'(n_fall0 - b_fall0), 32'd0);

    // Async reset mid-press while long is high.
    cyc(40);
    check("pre_rst_long", 32'(long_a), 32'b01);
    check("r0_n_rpt_2nd", 32'(n_rpt_r - b_rpt_r), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'({out_a, rise_a, fall_a, long_a, rpt_a, tick_a}), 32'd0);
    check("async_rst_r0_long", 32'(long_r), 32'd0);
    snap();
    cyc(2);  check("in_rst_out", 32'(out_a), 32'd0);
    rst_n = 1'b1;                 // input still pressed; full latency again
    cyc(13); check("redet_out_e13", 32'(out_a), 32'b00);
    cyc(1);  check("redet_out_e14", 32'(out_a), 32'b01);
    check("redet_rise_e14", 32'(rise_a), 32'b01);
    cyc(5);  #1;
    check("rst_n_fall0", 32'(n_fall0 - b_fall0), 32'd0);
    check("redet_n_rise0", 32'(n_rise0 - b_rise0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
